// File: rtl/pre_intlv_pkg.sv
// rtl/pre_intlv_pkg.sv - shared state encoding, default sizes and helpers for the pre-interleaver path
package pre_intlv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_FRAME_WORDS = 70;
    localparam int DEF_DATA_W      = 32;

    // Never returns less than 1 so single-value counters still get a bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/intlv_out_slice.sv
// rtl/intlv_out_slice.sv - single-entry output register toward the interleaver write port
module intlv_out_slice #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_last_i,
    output logic              can_load_o,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    output logic              m_tlast_o,
    input  logic              m_tready_i
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    // A new word may enter when the slot is empty or is being emptied this cycle.
    assign can_load_o = !valid_q || m_tready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_i) begin
            data_d  = load_data_i;
            last_d  = load_last_i;
            valid_d = 1'b1;
        end else if (valid_q && m_tready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign m_tdata_o  = data_q;
    assign m_tvalid_o = valid_q;
    assign m_tlast_o  = last_q;

endmodule

// File: rtl/codeword_rr_scheduler.sv
// rtl/codeword_rr_scheduler.sv - strict round-robin merge of encoder codeword lanes into interleaver column order
module codeword_rr_scheduler
    import pre_intlv_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_LANES*DATA_W-1:0] s_tdata,
    input  logic [NUM_LANES-1:0]        s_tvalid,
    input  logic [NUM_LANES-1:0]        s_tlast,
    output logic [NUM_LANES-1:0]        s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic                        frame_done,
    output logic [15:0]                 frame_count,
    output logic                        len_err,
    output logic                        busy
);

    localparam int LANE_W = clog2(NUM_LANES);
    localparam int WORD_W = clog2(FRAME_WORDS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

    sched_state_e      state_q, state_d;
    logic [LANE_W-1:0] lane_sel_q, lane_sel_d;
    logic [WORD_W-1:0] word_idx_q, word_idx_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              len_err_q, len_err_d;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              can_load;
    logic              run_ready;
    logic              lane_hs;
    logic              out_hs;
    logic              block_end;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_sel_q == LANE_W'(i)) begin
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Only the current lane is ever offered ready, so a stalled lane holds the whole block.
    assign run_ready = (state_q == ST_RUN) && can_load;

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            s_tready[i] = run_ready && (lane_sel_q == LANE_W'(i));
        end
    end

    assign lane_hs   = run_ready && sel_valid;
    assign out_hs    = m_tvalid && m_tready;
    assign block_end = (lane_sel_q == LAST_LANE) && (word_idx_q == LAST_WORD);

    always_comb begin
        state_d       = state_q;
        lane_sel_d    = lane_sel_q;
        word_idx_d    = word_idx_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        len_err_d     = len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lane_hs) begin
                    if (sel_last != (word_idx_q == LAST_WORD)) begin
                        len_err_d = 1'b1;
                    end
                    if (block_end) begin
                        lane_sel_d = '0;
                        word_idx_d = '0;
                        state_d    = ST_DRAIN;
                    end else if (lane_sel_q == LAST_LANE) begin
                        lane_sel_d = '0;
                        word_idx_d = word_idx_q + 1'b1;
                    end else begin
                        lane_sel_d = lane_sel_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Output slot holds only the block's final word here.
                if (out_hs) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lane_sel_q    <= '0;
            word_idx_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_sel_q    <= lane_sel_d;
            word_idx_q    <= word_idx_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            len_err_q     <= len_err_d;
        end
    end

    intlv_out_slice #(
        .DATA_W(DATA_W)
    ) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lane_hs),
        .load_data_i(sel_data),
        .load_last_i(block_end),
        .can_load_o (can_load),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tlast_o  (m_tlast),
        .m_tready_i (m_tready)
    );

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign len_err     = len_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_codeword_rr_scheduler.sv
// tb/tb_codeword_rr_scheduler.sv - scoreboard bench for codeword_rr_scheduler
module tb_codeword_rr_scheduler;

    localparam int NL = 4;
    localparam int FW = 70;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [NL*DW-1:0] s_tdata = '0;
    logic [NL-1:0]  s_tvalid = '0;
    logic [NL-1:0]  s_tlast = '0;
    logic [NL-1:0]  s_tready;
    logic [DW-1:0]  m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic           m_tlast;
    logic           frame_done;
    logic [15:0]    frame_count;
    logic           len_err;
    logic           busy;

    always #5 clk = ~clk;

    codeword_rr_scheduler #(
        .NUM_LANES  (NL),
        .FRAME_WORDS(FW),
        .DATA_W     (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .len_err    (len_err),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    int          k_lane[NL];
    int          exp_lane = 0;
    int          exp_word = 0;
    int          frame_out = 0;
    int          out_total = 0;
    int          fc_exp = 0;
    logic        done_exp = 1'b0;
    logic        lerr_exp = 1'b0;
    logic        held = 1'b0;
    logic [DW-1:0] held_data = '0;
    int          stall_lane = -1;
    int          stall_word = 0;
    int          stall_left = 0;
    int          mt_stall_at = -1;
    int          mt_stall_left = 0;
    int          en_drop_at = -1;
    int          inj_lane = -1;
    int          inj_word = 0;
    int          base;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor(input logic stall_now);
        logic [NL-1:0] hs;
        logic          e_last;
        logic [31:0]   e_data;
        hs = s_tvalid & s_tready;
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, done_exp});
        if (done_exp) begin
            fc_exp++;
            check_eq("frame_count", {16'd0, frame_count}, fc_exp);
        end
        done_exp = 1'b0;
        check_eq("ready_onehot", {31'd0, $onehot0(s_tready)}, 32'd1);
        if (held) begin
            check_eq("hold_valid", {31'd0, m_tvalid}, 32'd1);
            check_eq("hold_data", m_tdata, held_data);
        end
        if (m_tvalid && !m_tready) begin
            check_eq("stall_ready", {28'd0, s_tready}, 32'd0);
        end
        if (stall_now && (!m_tvalid || m_tready)) begin
            check_eq("no_skip", {28'd0, s_tready}, 32'd1 << stall_lane);
        end
        held = m_tvalid && !m_tready;
        held_data = m_tdata;
        if (m_tvalid && m_tready) begin
            out_total++;
            frame_out++;
            check_eq("sb_nonempty", {31'd0, exp_data.size() != 0}, 32'd1);
            if (exp_data.size() != 0) begin
                e_data = exp_data.pop_front();
                e_last = exp_last.pop_front();
                check_eq("out_data", m_tdata, e_data);
                check_eq("out_last", {31'd0, m_tlast}, {31'd0, e_last});
                if (e_last) begin
                    check_eq("tlast_pos", frame_out, NL * FW);
                    frame_out = 0;
                    done_exp = 1'b1;
                end
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (hs[i]) begin
                check_eq("lane_order", i, exp_lane);
                exp_data.push_back({16'(exp_lane), 16'(exp_word)});
                exp_last.push_back(exp_lane == NL - 1 && exp_word == FW - 1);
                if (s_tlast[i] != (exp_word == FW - 1)) lerr_exp = 1'b1;
                k_lane[i] = (k_lane[i] + 1) % FW;
                if (exp_lane == NL - 1) begin
                    exp_lane = 0;
                    exp_word = (exp_word + 1) % FW;
                end else begin
                    exp_lane++;
                end
            end
        end
    endtask

    task automatic cycle();
        logic stall_now;
        @(negedge clk);
        stall_now = (stall_left > 0) && (exp_lane == stall_lane) && (exp_word == stall_word);
        if (stall_now) stall_left--;
        m_tready = 1'b1;
        if (mt_stall_at >= 0 && mt_stall_left > 0 && frame_out >= mt_stall_at) begin
            m_tready = 1'b0;
            mt_stall_left--;
        end
        if (en_drop_at >= 0 && frame_out >= en_drop_at) enable = 1'b0;
        for (int i = 0; i < NL; i++) begin
            s_tdata[i*DW +: DW] = {16'(i), 16'(k_lane[i])};
            s_tvalid[i] = !(stall_now && i == stall_lane);
            s_tlast[i] = (k_lane[i] == FW - 1) ^ (i == inj_lane && k_lane[i] == inj_word);
        end
        #1;
        monitor(stall_now);
    endtask

    task automatic run_until_frames(input int target, input int budget);
        int n;
        n = 0;
        while (fc_exp < target && n < budget) begin
            cycle();
            n++;
        end
        check_eq("frame_timeout", {31'd0, fc_exp >= target}, 32'd1);
    endtask

    task automatic run_until_out(input int target, input int budget);
        int n;
        n = 0;
        while (frame_out < target && n < budget) begin
            cycle();
            n++;
        end
        check_eq("out_timeout", {31'd0, frame_out >= target}, 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check_eq("rst_m_tdata", m_tdata, 32'd0);
        check_eq("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        check_eq("rst_s_tready", {28'd0, s_tready}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check_eq("rst_len_err", {31'd0, len_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < NL; i++) k_lane[i] = 0;
        exp_lane = 0;
        exp_word = 0;
        frame_out = 0;
        fc_exp = 0;
        done_exp = 1'b0;
        lerr_exp = 1'b0;
        held = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NL; i++) k_lane[i] = 0;
        enable = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '1;
        apply_reset();

        // Plain block, all lanes ready
        run_until_frames(1, 1000);
        check_eq("len_err_clean", {31'd0, len_err}, {31'd0, lerr_exp});

        // Lane 2 starves at word 5, then output back-pressure mid-block
        stall_lane = 2;
        stall_word = 5;
        stall_left = 10;
        mt_stall_at = 150;
        mt_stall_left = 7;
        run_until_frames(2, 1000);
        check_eq("frame_count_2", {16'd0, frame_count}, 32'd2);

        // Bad tlast on lane 1 word 3, enable dropped at output word 100
        inj_lane = 1;
        inj_word = 3;
        en_drop_at = 100;
        run_until_frames(3, 1000);
        inj_lane = -1;
        en_drop_at = -1;
        check_eq("len_err_set", {31'd0, len_err}, {31'd0, lerr_exp});
        base = out_total;
        repeat (20) cycle();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_ready", {28'd0, s_tready}, 32'd0);
        check_eq("idle_no_out", out_total - base, 32'd0);
        check_eq("len_err_sticky", {31'd0, len_err}, 32'd1);
        check_eq("frame_count_idle", {16'd0, frame_count}, 32'd3);

        // Reset in the middle of a block
        enable = 1'b1;
        run_until_out(150, 1000);
        check_eq("len_err_hold", {31'd0, len_err}, 32'd1);
        #2;
        apply_reset();
        run_until_frames(1, 1000);
        check_eq("frame_count_post_rst", {16'd0, frame_count}, 32'd1);
        check_eq("len_err_post_rst", {31'd0, len_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
